// File: rtl/axi_arb2_pkg.sv
// axi_arb_pkg: shared types for the two-master AXI4 arbiter.
//   src_e         : which upstream master a transaction belongs to
//   wfsm_e        : write-ownership state machine states
//   ID_PREFIX_BIT : position of the source bit in the downstream ID
//                   (equals the upstream ID width for the default build)
package axi_arb_pkg;
  typedef enum logic {SRC_CORE = 1'b0, SRC_DBG = 1'b1} src_e;
  typedef enum logic {W_IDLE = 1'b0, W_DATA = 1'b1} wfsm_e;

  localparam int DEF_ID_W      = 4;
  localparam int DEF_ADDR_W    = 64;
  localparam int DEF_DATA_W    = 64;
  localparam int ID_PREFIX_BIT = DEF_ID_W;
endpackage

// File: rtl/axi_arb2_if.sv
// axi_arb2_if: one full AXI4 port (AW/W/B/AR/R).
//   master modport : drives AW/W/AR payload+valid, B/R ready
//   slave  modport : drives AW/W/AR ready, B/R payload+valid
// Parameters ID_W/ADDR_W/DATA_W size the fields; WSTRB is DATA_W/8 wide.
interface axi_arb2_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid, arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_arb2_rr.sv
// rr_arb2: two-way round-robin arbiter with grant lock.
//   req[1:0] : request per source
//   lock     : downstream valid seen without ready -> freeze current winner
//   hs       : downstream handshake -> release lock, advance pointer
//   gnt[1:0] : one-hot grant (masked by req)
//   src      : index of the winner
// AXI_ARB_FIXED_PRIO_EN: when defined, source 0 always wins a contest and
// the pointer is removed; the grant lock is kept.
import axi_arb_pkg::*;

module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       hs,
  output logic [1:0] gnt,
  output src_e       src
);
  logic locked_q, locked_d;
  src_e lsrc_q, lsrc_d;
  src_e pref, other;

`ifdef AXI_ARB_FIXED_PRIO_EN
  assign pref = SRC_CORE;
`else
  src_e ptr_q, ptr_d;
  assign pref = ptr_q;

  // After a handshake the loser becomes the preferred requester.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = src_e'(~src);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= SRC_CORE;
    else         ptr_q <= ptr_d;
`endif

  assign other = src_e'(~pref);

  always_comb begin
    src = pref;
    if (locked_q)       src = lsrc_q;   // stalled request must not switch
    else if (req[pref]) src = pref;
    else if (req[other]) src = other;
    gnt      = '0;
    gnt[src] = req[src];
    locked_d = locked_q;
    lsrc_d   = lsrc_q;
    if (hs) begin
      locked_d = 1'b0;
    end else if (lock) begin
      locked_d = 1'b1;
      lsrc_d   = src;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      locked_q <= 1'b0;
      lsrc_q   <= SRC_CORE;
    end else begin
      locked_q <= locked_d;
      lsrc_q   <= lsrc_d;
    end
endmodule

// File: rtl/axi_arb2.sv
// axi_arb2: shares one downstream AXI4 master port between s0 (core) and
// s1 (debug/DMA loader).
//   clk_i, rst_ni : clock, async active-low reset
//   s0, s1        : upstream ports (ID_W-bit IDs)
//   m             : downstream port (ID_W+1-bit IDs, MSB = source)
// AR and AW are arbitrated independently; W follows the AW owner until
// wlast so bursts never interleave; B/R are routed by the ID MSB.
// Optional macro AXI_ARB_FIXED_PRIO_EN selects fixed s0 priority.
import axi_arb_pkg::*;

module axi_arb2 #(
  parameter int ID_W   = DEF_ID_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  axi_arb2_if.slave   s0,
  axi_arb2_if.slave   s1,
  axi_arb2_if.master  m
);
  wfsm_e      wstate_q, wstate_d;
  src_e       owner_q, owner_d;
  logic [1:0] ar_gnt, aw_gnt;
  src_e       ar_src, aw_src;
  logic       ar_dbg, aw_dbg, w_dbg, w_idle;
  logic       ar_hs, aw_hs, w_hs;

  // ---------------- AR ----------------
  rr_arb2 u_ar_arb (
    .clk_i, .rst_ni,
    .req ({s1.arvalid, s0.arvalid}),
    .lock(m.arvalid & ~m.arready),
    .hs  (ar_hs),
    .gnt (ar_gnt),
    .src (ar_src)
  );
  assign ar_dbg     = (ar_src == SRC_DBG);
  assign m.arvalid  = |ar_gnt;
  assign ar_hs      = m.arvalid & m.arready;
  assign s0.arready = ar_gnt[0] & m.arready;
  assign s1.arready = ar_gnt[1] & m.arready;
  assign m.arid     = {ar_dbg, ar_dbg ? s1.arid : s0.arid};
  assign m.araddr   = ar_dbg ? s1.araddr  : s0.araddr;
  assign m.arlen    = ar_dbg ? s1.arlen   : s0.arlen;
  assign m.arsize   = ar_dbg ? s1.arsize  : s0.arsize;
  assign m.arburst  = ar_dbg ? s1.arburst : s0.arburst;
  assign m.arlock   = ar_dbg ? s1.arlock  : s0.arlock;
  assign m.arcache  = ar_dbg ? s1.arcache : s0.arcache;
  assign m.arprot   = ar_dbg ? s1.arprot  : s0.arprot;
  assign m.arqos    = ar_dbg ? s1.arqos   : s0.arqos;

  // ---------------- AW ----------------
  // AW requests are hidden while a burst owns W, so no grant (and no lock)
  // can form until the owner's last beat.
  assign w_idle = (wstate_q == W_IDLE);

  rr_arb2 u_aw_arb (
    .clk_i, .rst_ni,
    .req ({s1.awvalid, s0.awvalid} & {2{w_idle}}),
    .lock(m.awvalid & ~m.awready),
    .hs  (aw_hs),
    .gnt (aw_gnt),
    .src (aw_src)
  );
  assign aw_dbg     = (aw_src == SRC_DBG);
  assign m.awvalid  = |aw_gnt;
  assign aw_hs      = m.awvalid & m.awready;
  assign s0.awready = aw_gnt[0] & m.awready;
  assign s1.awready = aw_gnt[1] & m.awready;
  assign m.awid     = {aw_dbg, aw_dbg ? s1.awid : s0.awid};
  assign m.awaddr   = aw_dbg ? s1.awaddr  : s0.awaddr;
  assign m.awlen    = aw_dbg ? s1.awlen   : s0.awlen;
  assign m.awsize   = aw_dbg ? s1.awsize  : s0.awsize;
  assign m.awburst  = aw_dbg ? s1.awburst : s0.awburst;
  assign m.awlock   = aw_dbg ? s1.awlock  : s0.awlock;
  assign m.awcache  = aw_dbg ? s1.awcache : s0.awcache;
  assign m.awprot   = aw_dbg ? s1.awprot  : s0.awprot;
  assign m.awqos    = aw_dbg ? s1.awqos   : s0.awqos;

  // ---------------- W ownership ----------------
  always_comb begin
    wstate_d = wstate_q;
    owner_d  = owner_q;
    case (wstate_q)
      W_IDLE: if (aw_hs) begin
        owner_d  = aw_src;
        wstate_d = W_DATA;
      end
      W_DATA: if (w_hs && m.wlast) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wstate_q <= W_IDLE;
      owner_q  <= SRC_CORE;
    end else begin
      wstate_q <= wstate_d;
      owner_q  <= owner_d;
    end

  // W beats that show up before their AW see wready=0 until ownership.
  assign w_dbg     = (owner_q == SRC_DBG);
  assign m.wvalid  = ~w_idle & (w_dbg ? s1.wvalid : s0.wvalid);
  assign m.wdata   = w_dbg ? s1.wdata : s0.wdata;
  assign m.wstrb   = w_dbg ? s1.wstrb : s0.wstrb;
  assign m.wlast   = w_dbg ? s1.wlast : s0.wlast;
  assign w_hs      = m.wvalid & m.wready;
  assign s0.wready = ~w_idle & ~w_dbg & m.wready;
  assign s1.wready = ~w_idle &  w_dbg & m.wready;

  // ---------------- B / R routing ----------------
  assign s0.bvalid = m.bvalid & ~m.bid[ID_W];
  assign s1.bvalid = m.bvalid &  m.bid[ID_W];
  assign s0.bid    = m.bid[ID_W-1:0];
  assign s1.bid    = m.bid[ID_W-1:0];
  assign s0.bresp  = m.bresp;
  assign s1.bresp  = m.bresp;
  assign m.bready  = m.bvalid & (m.bid[ID_W] ? s1.bready : s0.bready);

  assign s0.rvalid = m.rvalid & ~m.rid[ID_W];
  assign s1.rvalid = m.rvalid &  m.rid[ID_W];
  assign s0.rid    = m.rid[ID_W-1:0];
  assign s1.rid    = m.rid[ID_W-1:0];
  assign s0.rdata  = m.rdata;
  assign s1.rdata  = m.rdata;
  assign s0.rresp  = m.rresp;
  assign s1.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rlast  = m.rlast;
  assign m.rready  = m.rvalid & (m.rid[ID_W] ? s1.rready : s0.rready);
endmodule

// File: tb/tb_axi_arb2.sv
// tb_axi_arb2: directed stimulus with a scoreboard. Stimulus pushes the
// hand-computed downstream/upstream transfers into per-channel queues; a
// negedge monitor pops and compares on every handshake and also checks
// that a stalled m_ar/m_aw request keeps its payload.
import axi_arb_pkg::*;

module tb_axi_arb2;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_arb2_if #(.ID_W(4), .ADDR_W(64), .DATA_W(64)) s0_if ();
  axi_arb2_if #(.ID_W(4), .ADDR_W(64), .DATA_W(64)) s1_if ();
  axi_arb2_if #(.ID_W(5), .ADDR_W(64), .DATA_W(64)) m_if ();

  axi_arb2 #(.ID_W(4), .ADDR_W(64), .DATA_W(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .s0(s0_if), .s1(s1_if), .m(m_if)
  );

  typedef struct { logic [4:0] id; logic [63:0] addr; logic [7:0] len; } ax_t;
  typedef struct { logic [63:0] data; logic last; } w_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic last; } r_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

  ax_t exp_ar[$], exp_aw[$];
  w_t  exp_w[$];
  r_t  exp_r0[$], exp_r1[$];
  b_t  exp_b0[$], exp_b1[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        ar_pend = 0, aw_pend = 0;
  logic [4:0]  ar_id_h, aw_id_h;
  logic [63:0] ar_addr_h, aw_addr_h;
  ax_t e_ax; w_t e_w; r_t e_r; b_t e_b;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      ar_pend = 0;
      aw_pend = 0;
    end else begin
      if (ar_pend) begin
        chk("ar_hold_valid", m_if.arvalid, 1);
        chk("ar_hold_id", m_if.arid, ar_id_h);
        chk("ar_hold_addr", m_if.araddr, ar_addr_h);
      end
      ar_pend = m_if.arvalid && !m_if.arready;
      ar_id_h = m_if.arid; ar_addr_h = m_if.araddr;
      if (aw_pend) begin
        chk("aw_hold_valid", m_if.awvalid, 1);
        chk("aw_hold_id", m_if.awid, aw_id_h);
        chk("aw_hold_addr", m_if.awaddr, aw_addr_h);
      end
      aw_pend = m_if.awvalid && !m_if.awready;
      aw_id_h = m_if.awid; aw_addr_h = m_if.awaddr;

      if (m_if.arvalid && m_if.arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", m_if.arvalid, 0);
        else begin
          e_ax = exp_ar.pop_front();
          chk("ar_id", m_if.arid, e_ax.id);
          chk("ar_addr", m_if.araddr, e_ax.addr);
          chk("ar_len", m_if.arlen, e_ax.len);
        end
      end
      if (m_if.awvalid && m_if.awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", m_if.awvalid, 0);
        else begin
          e_ax = exp_aw.pop_front();
          chk("aw_id", m_if.awid, e_ax.id);
          chk("aw_addr", m_if.awaddr, e_ax.addr);
          chk("aw_len", m_if.awlen, e_ax.len);
        end
      end
      if (m_if.wvalid && m_if.wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", m_if.wvalid, 0);
        else begin
          e_w = exp_w.pop_front();
          chk("w_data", m_if.wdata, e_w.data);
          chk("w_last", m_if.wlast, e_w.last);
        end
      end
      if (s0_if.rvalid && s0_if.rready) begin
        if (exp_r0.size() == 0) chk("r0_unexpected", s0_if.rvalid, 0);
        else begin
          e_r = exp_r0.pop_front();
          chk("r0_id", s0_if.rid, e_r.id);
          chk("r0_data", s0_if.rdata, e_r.data);
          chk("r0_last", s0_if.rlast, e_r.last);
        end
      end
      if (s1_if.rvalid && s1_if.rready) begin
        if (exp_r1.size() == 0) chk("r1_unexpected", s1_if.rvalid, 0);
        else begin
          e_r = exp_r1.pop_front();
          chk("r1_id", s1_if.rid, e_r.id);
          chk("r1_data", s1_if.rdata, e_r.data);
          chk("r1_last", s1_if.rlast, e_r.last);
        end
      end
      if (s0_if.bvalid && s0_if.bready) begin
        if (exp_b0.size() == 0) chk("b0_unexpected", s0_if.bvalid, 0);
        else begin
          e_b = exp_b0.pop_front();
          chk("b0_id", s0_if.bid, e_b.id);
          chk("b0_resp", s0_if.bresp, e_b.resp);
        end
      end
      if (s1_if.bvalid && s1_if.bready) begin
        if (exp_b1.size() == 0) chk("b1_unexpected", s1_if.bvalid, 0);
        else begin
          e_b = exp_b1.pop_front();
          chk("b1_id", s1_if.bid, e_b.id);
          chk("b1_resp", s1_if.bresp, e_b.resp);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic ar_send(input bit src, input logic [3:0] id, input logic [63:0] addr,
                         input logic [7:0] len);
    bit done = 0;
    if (src) begin
      s1_if.arid = id; s1_if.araddr = addr; s1_if.arlen = len; s1_if.arvalid = 1;
    end else begin
      s0_if.arid = id; s0_if.araddr = addr; s0_if.arlen = len; s0_if.arvalid = 1;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = src ? s1_if.arready : s0_if.arready;
    end
    if (!done) chk("ar_accept_timeout", 0, 1);
    tick();
    if (src) s1_if.arvalid = 0; else s0_if.arvalid = 0;
  endtask

  task automatic aw_send(input bit src, input logic [3:0] id, input logic [63:0] addr,
                         input logic [7:0] len);
    bit done = 0;
    if (src) begin
      s1_if.awid = id; s1_if.awaddr = addr; s1_if.awlen = len; s1_if.awvalid = 1;
    end else begin
      s0_if.awid = id; s0_if.awaddr = addr; s0_if.awlen = len; s0_if.awvalid = 1;
    end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = src ? s1_if.awready : s0_if.awready;
    end
    if (!done) chk("aw_accept_timeout", 0, 1);
    tick();
    if (src) s1_if.awvalid = 0; else s0_if.awvalid = 0;
  endtask

  task automatic w_send(input bit src, input logic [63:0] data, input bit last);
    bit done = 0;
    if (src) begin s1_if.wdata = data; s1_if.wlast = last; s1_if.wvalid = 1; end
    else     begin s0_if.wdata = data; s0_if.wlast = last; s0_if.wvalid = 1; end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = src ? s1_if.wready : s0_if.wready;
    end
    if (!done) chk("w_accept_timeout", 0, 1);
    tick();
    if (src) s1_if.wvalid = 0; else s0_if.wvalid = 0;
  endtask

  task automatic r_send(input logic [4:0] id, input logic [63:0] data, input bit last);
    bit done = 0;
    m_if.rid = id; m_if.rdata = data; m_if.rlast = last; m_if.rresp = 0; m_if.rvalid = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = m_if.rready;
    end
    if (!done) chk("r_accept_timeout", 0, 1);
    tick();
    m_if.rvalid = 0;
  endtask

  task automatic b_send(input logic [4:0] id, input logic [1:0] resp);
    bit done = 0;
    m_if.bid = id; m_if.bresp = resp; m_if.bvalid = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      done = m_if.bready;
    end
    if (!done) chk("b_accept_timeout", 0, 1);
    tick();
    m_if.bvalid = 0;
  endtask

  task automatic rst_pulse();
    rst_ni = 0; tick(); rst_ni = 1; tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    {s0_if.arvalid, s0_if.awvalid, s0_if.wvalid, s1_if.arvalid, s1_if.awvalid, s1_if.wvalid} = '0;
    s0_if.arid = 0; s0_if.araddr = 0; s0_if.arlen = 0; s0_if.arsize = 3; s0_if.arburst = 1;
    s0_if.arlock = 0; s0_if.arcache = 0; s0_if.arprot = 0; s0_if.arqos = 0;
    s0_if.awid = 0; s0_if.awaddr = 0; s0_if.awlen = 0; s0_if.awsize = 3; s0_if.awburst = 1;
    s0_if.awlock = 0; s0_if.awcache = 0; s0_if.awprot = 0; s0_if.awqos = 0;
    s0_if.wdata = 0; s0_if.wstrb = '1; s0_if.wlast = 0;
    s1_if.arid = 0; s1_if.araddr = 0; s1_if.arlen = 0; s1_if.arsize = 3; s1_if.arburst = 1;
    s1_if.arlock = 0; s1_if.arcache = 0; s1_if.arprot = 0; s1_if.arqos = 0;
    s1_if.awid = 0; s1_if.awaddr = 0; s1_if.awlen = 0; s1_if.awsize = 3; s1_if.awburst = 1;
    s1_if.awlock = 0; s1_if.awcache = 0; s1_if.awprot = 0; s1_if.awqos = 0;
    s1_if.wdata = 0; s1_if.wstrb = '1; s1_if.wlast = 0;
    s0_if.bready = 1; s0_if.rready = 1; s1_if.bready = 1; s1_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    m_if.bid = 0; m_if.bresp = 0; m_if.bvalid = 0;
    m_if.rid = 0; m_if.rdata = 0; m_if.rresp = 0; m_if.rlast = 0; m_if.rvalid = 0;

    // Reset state: downstream ready high, stray W from s0, nothing may pass.
    s0_if.wvalid = 1;
    @(negedge clk_i);
    chk("rst_m_arvalid", m_if.arvalid, 0);
    chk("rst_m_awvalid", m_if.awvalid, 0);
    chk("rst_m_wvalid", m_if.wvalid, 0);
    chk("rst_m_bready", m_if.bready, 0);
    chk("rst_m_rready", m_if.rready, 0);
    chk("rst_s0_wready", s0_if.wready, 0);
    chk("rst_s0_arready", s0_if.arready, 0);
    chk("rst_s1_awready", s1_if.awready, 0);
    chk("rst_s0_rvalid", s0_if.rvalid, 0);
    chk("rst_s1_bvalid", s1_if.bvalid, 0);
    s0_if.wvalid = 0;
    tick(); rst_ni = 1; tick();

    // Single read from s0, four beats routed back to s0 only.
    exp_ar.push_back('{5'h03, 64'h8000_0000, 8'd3});
    ar_send(0, 4'h3, 64'h8000_0000, 8'd3);
    for (int i = 0; i < 4; i++) begin
      exp_r0.push_back('{4'h3, 64'h100 + 64'(i), (i == 3)});
      r_send(5'h03, 64'h100 + 64'(i), (i == 3));
    end

    // Contended AR: s0 wins first, then s1 (pointer flipped), then s0 again.
    rst_pulse();
    exp_ar.push_back('{5'h01, 64'hA000, 8'd0});
    exp_ar.push_back('{5'h12, 64'hB000, 8'd0});
    exp_ar.push_back('{5'h03, 64'hC000, 8'd0});
    fork
      begin ar_send(0, 4'h1, 64'hA000, 0); ar_send(0, 4'h3, 64'hC000, 0); end
      ar_send(1, 4'h2, 64'hB000, 0);
    join
    exp_r1.push_back('{4'h2, 64'h55, 1'b1});
    r_send(5'h12, 64'h55, 1);
    exp_r0.push_back('{4'h1, 64'h66, 1'b1});
    r_send(5'h01, 64'h66, 1);

    // Stall stability: s1 granted and stalled 5 cycles while s0 asks.
    m_if.arready = 0;
    exp_ar.push_back('{5'h17, 64'h1000, 8'd0});
    exp_ar.push_back('{5'h09, 64'h2000, 8'd0});
    fork
      ar_send(1, 4'h7, 64'h1000, 0);
      begin tick(); ar_send(0, 4'h9, 64'h2000, 0); end
      begin repeat (5) @(posedge clk_i); #1; m_if.arready = 1; end
    join

    // Write exclusivity: s0 burst of 4 completes before s1's AW/W.
    exp_aw.push_back('{5'h04, 64'hC000, 8'd3});
    exp_aw.push_back('{5'h15, 64'hD000, 8'd0});
    for (int i = 0; i < 4; i++) exp_w.push_back('{64'hA0 + 64'(i), (i == 3)});
    exp_w.push_back('{64'hB0, 1'b1});
    fork
      aw_send(0, 4'h4, 64'hC000, 3);
      aw_send(1, 4'h5, 64'hD000, 0);
      begin for (int i = 0; i < 4; i++) w_send(0, 64'hA0 + 64'(i), (i == 3)); end
      w_send(1, 64'hB0, 1);
    join
    exp_b0.push_back('{4'h4, 2'd0});
    b_send(5'h04, 0);
    exp_b1.push_back('{4'h5, 2'd1});
    b_send(5'h15, 1);

    // W before AW: s1's beat waits for its AW.
    exp_aw.push_back('{5'h16, 64'hE000, 8'd0});
    exp_w.push_back('{64'hC0, 1'b1});
    fork
      w_send(1, 64'hC0, 1);
      begin
        repeat (3) begin @(negedge clk_i); chk("w_early_wready", s1_if.wready, 0); end
        tick();
        aw_send(1, 4'h6, 64'hE000, 0);
      end
    join

    // Reset in the middle of an s0 burst.
    exp_aw.push_back('{5'h07, 64'hF000, 8'd3});
    exp_w.push_back('{64'hD0, 1'b0});
    aw_send(0, 4'h7, 64'hF000, 3);
    w_send(0, 64'hD0, 0);
    s0_if.wdata = 64'hD1; s0_if.wlast = 0; s0_if.wvalid = 1;
    #2 rst_ni = 0;
    @(negedge clk_i);
    chk("mid_rst_m_wvalid", m_if.wvalid, 0);
    chk("mid_rst_s0_wready", s0_if.wready, 0);
    chk("mid_rst_m_awvalid", m_if.awvalid, 0);
    chk("mid_rst_s0_awready", s0_if.awready, 0);
    s0_if.wvalid = 0;
    tick(); rst_ni = 1;
    exp_aw.push_back('{5'h18, 64'h9000, 8'd0});
    s1_if.awid = 4'h8; s1_if.awaddr = 64'h9000; s1_if.awlen = 0; s1_if.awvalid = 1;
    @(negedge clk_i);
    chk("post_rst_aw_immediate", s1_if.awready, 1);
    tick(); s1_if.awvalid = 0;
    exp_w.push_back('{64'hE0, 1'b1});
    w_send(1, 64'hE0, 1);

    repeat (3) tick();
    chk("left_ar", exp_ar.size(), 0);
    chk("left_aw", exp_aw.size(), 0);
    chk("left_w", exp_w.size(), 0);
    chk("left_r", exp_r0.size() + exp_r1.size(), 0);
    chk("left_b", exp_b0.size() + exp_b1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
endmodule
